seven_seg_scan_driver: RTL and testbench

//  Display back-end for the processor top level: takes two unsigned binary values (low bits of v0/v1)
//  and converts each to BCD with a sequential double-dabble. Time-multiplexes the resulting 8 digits onto
//  one shared active-low 7-segment bus with active-low digit enables. Sits directly downstream of the

---
 rtl/display_pkg.sv | 63 ++++++
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/seven_seg_scan_driver.sv | 120 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, state encoding and decode helpers for the seven-segment scan driver.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  // Non-decimal nibbles cannot come out of the converter; show them blank anyway.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return adj;
  endfunction

  // Bit i set means nibble i is a leading zero; nibble 0 is never blanked.
  function automatic logic [3:0] lead_zero_mask(input logic [BCD_W-1:0] bcd);
    logic [3:0] m;
    m[3] = (bcd[15:12] == 4'd0);
    m[2] = m[3] && (bcd[11:8] == 4'd0);
    m[1] = m[2] && (bcd[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads the binary value, then WIDTH shift cycles build 4 BCD digits.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_adj;

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bcd_adj = bcd_adjust(bcd_q);
    if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = CNT_INIT;
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      cnt_d          = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  // High during the final shift, so bcd_out is complete right after this edge.
  assign done    = (cnt_q == CNT_ONE) && !start;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Two-number BCD display scanner driving a shared active-low 7-segment bus and one-cold digit enables.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros within each 4-digit half.
module seven_seg_scan_driver
  import display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] NumberA,
  input  logic [WIDTH-1:0] NumberB,
  output logic [6:0]       out7,
  output logic [7:0]       en_out
);

  localparam int               PRE_W    = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  conv_state_t state_q, state_d;
  logic        conv_start;
  logic        done_a, done_b;
  logic [BCD_W-1:0] bcd_a, bcd_b;

  logic [BCD_W-1:0] disp_a_q, disp_a_d;
  logic [BCD_W-1:0] disp_b_q, disp_b_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       out7_q, out7_d;
  logic [7:0]       en_q, en_d;

  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0]      blank;

  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv_a (
    .Clk     (Clk),
    .Rst     (Rst),
    .start   (conv_start),
    .bin_in  (NumberA),
    .done    (done_a),
    .bcd_out (bcd_a)
  );

  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv_b (
    .Clk     (Clk),
    .Rst     (Rst),
    .start   (conv_start),
    .bin_in  (NumberB),
    .done    (done_b),
    .bcd_out (bcd_b)
  );

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    disp_a_d   = disp_a_q;
    disp_b_d   = disp_b_q;
    case (state_q)
      IDLE: begin
        conv_start = 1'b1;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (done_a && done_b) state_d = LOAD;
      end
      LOAD: begin
        // Both halves update together so the display never mixes old and new values.
        disp_a_d = bcd_a;
        disp_b_d = bcd_b;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    digits = {disp_a_q, disp_b_q};
`ifdef LEADING_ZERO_BLANK_EN
    blank  = {lead_zero_mask(disp_a_q), lead_zero_mask(disp_b_q)};
`else
    blank  = '0;
`endif
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 1'b1;
    end
    // Refreshed every cycle from the current idx, so a LOAD shows up one edge later.
    en_d   = ~(8'b1 << idx_q);
    out7_d = blank[idx_q] ? SEG_BLANK : seg_decode(digits[idx_q]);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      disp_a_q <= '0;
      disp_b_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      out7_q   <= SEG_BLANK;
      en_q     <= 8'hFF;
    end else begin
      state_q  <= state_d;
      disp_a_q <= disp_a_d;
      disp_b_q <= disp_b_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      out7_q   <= out7_d;
      en_q     <= en_d;
    end
  end

  assign out7   = out7_q;
  assign en_out = en_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: a decimal-arithmetic display model predicts each edge, a monitor checks after it.
module tb_seven_seg_scan_driver;

  localparam int WIDTH    = 8;
  localparam int SCAN_DIV = 4;
  localparam int PERIOD   = WIDTH + 2;

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic             Clk = 1'b0;
  logic             Rst;
  logic [WIDTH-1:0] NumberA, NumberB;
  logic [6:0]       out7;
  logic [7:0]       en_out;

  seven_seg_scan_driver #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .NumberA (NumberA),
    .NumberB (NumberB),
    .out7    (out7),
    .en_out  (en_out)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] en;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: edges since reset release, latched inputs, values on display.
  int n_edges = 0;
  int samp_a = 0, samp_b = 0, disp_a = 0, disp_b = 0;

  function automatic logic [6:0] ref_digit(input int value, input int pos);
    int d;
    d = (value / (10 ** pos)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos != 0 && value < 10 ** pos) return 7'h7F;
`endif
    return SEG_TAB[d];
  endfunction

  // Predict the outputs the upcoming edge registers, then advance the model across it.
  task automatic step();
    exp_t e;
    int   idx;
    int   v;
    idx   = (n_edges / SCAN_DIV) % 8;
    v     = (idx >= 4) ? disp_a : disp_b;
    e.seg = ref_digit(v, idx % 4);
    e.en  = 8'hFF;
    e.en[idx] = 1'b0;
    exp_q.push_back(e);
    if (n_edges % PERIOD == 0) begin
      samp_a = int'(NumberA);
      samp_b = int'(NumberB);
    end
    if (n_edges % PERIOD == WIDTH + 1) begin
      disp_a = samp_a;
      disp_b = samp_b;
    end
    n_edges++;
    @(negedge Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (out7 !== 7'h7F || en_out !== 8'hFF) begin
      miscompares++;
      $display("FAIL %s: out7=%h en_out=%h, expected out7=7f en_out=ff", tag, out7, en_out);
    end
  endtask

  task automatic do_reset(input int hold);
    Rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (hold) @(negedge Clk);
    check_reset_outputs("reset_hold");
    Rst     = 1'b0;
    n_edges = 0;
    samp_a  = 0;
    samp_b  = 0;
    disp_a  = 0;
    disp_b  = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (out7 !== e.seg || en_out !== e.en) begin
          miscompares++;
          $display("FAIL scan_out @%0t: out7=%h en_out=%h, expected out7=%h en_out=%h",
                   $time, out7, en_out, e.seg, e.en);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected stimulus to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    Rst     = 1'b0;
    NumberA = WIDTH'($urandom);
    NumberB = WIDTH'($urandom);
    #1;
    do_reset(1);

    // Free-running scan with static random inputs
    repeat (3 * PERIOD + 12) step();

    NumberA = 8'd255;
    NumberB = 8'd7;
    repeat (50) step();

    NumberA = 8'd0;
    NumberB = 8'd0;
    repeat (50) step();

    // Input change during SHIFT must not disturb the conversion in flight
    NumberA = 8'd123;
    NumberB = WIDTH'($urandom);
    while (n_edges % PERIOD != 0) step();
    repeat (3) step();
    NumberA = 8'd45;
    repeat (2 * PERIOD + 40) step();

    // Reset in the middle of SHIFT
    NumberA = 8'd201;
    NumberB = 8'd98;
    while (n_edges % PERIOD != 5) step();
    do_reset(2);
    repeat (3 * PERIOD + 36) step();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) NumberA = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) NumberB = WIDTH'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 3));
      step();
    end

    @(posedge Clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
